// File: rtl/sample_frame_uart.sv
// Snapshots N signed W-bit channels on a decimated sample_clk edge and sends them
// as one 8N1 UART frame: A5, {seq, N-1}, payload (channel 0 first, MSB byte first), XOR.
module sample_frame_uart #(
    parameter int N        = 4,
    parameter int W        = 16,
    parameter int CLK_DIV  = 12,
    parameter int DECIMATE = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           sample_clk,
    input  logic           en,
    input  logic [N*W-1:0] samples,
    output logic           tx_o,
    output logic           busy,
    output logic           overrun,
    output logic [3:0]     frame_seq
);
    localparam int BPC = W / 8;
    localparam int NB  = N * BPC;
    localparam int L   = NB + 3;
    localparam int CW  = $clog2(CLK_DIV);
    localparam int DW  = (DECIMATE > 1) ? $clog2(DECIMATE) : 1;
    localparam int IW  = $clog2(L + 1);
    localparam int PIW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t          state_q, state_d;
    logic            sc_q;
    logic [DW-1:0]   dcnt_q, dcnt_d;
    logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [IW-1:0]   byte_idx_q, byte_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      chk_q, chk_d;
    logic [3:0]      seq_q, seq_d;
    logic            started_q, started_d;
    logic            overrun_q, overrun_d;
    logic            tx_q, tx_d;
    logic [7:0]      snap_q [NB];
    logic [7:0]      snap_d [NB];
    logic [7:0]      sample_bytes [NB];

    logic            edge_det, capture, accept, bit_end;
    logic [IW-1:0]   nxt_idx, pay_idx;
    logic [7:0]      next_byte;

    // Reorder the live inputs into transmit order so the frame walks one flat byte array.
    for (genvar c = 0; c < N; c++) begin : g_chan
        for (genvar b = 0; b < BPC; b++) begin : g_byte
            assign sample_bytes[c*BPC + b] = samples[(c*W + (BPC-1-b)*8) +: 8];
        end
    end

    assign edge_det = sample_clk & ~sc_q;
    assign capture  = en & edge_det & (dcnt_q == '0);
    assign accept   = capture & (state_q == S_IDLE);
    assign bit_end  = (bit_cnt_q == CW'(CLK_DIV - 1));
    assign nxt_idx  = byte_idx_q + IW'(1);
    assign pay_idx  = byte_idx_q - IW'(1);

    always_comb begin
        next_byte = chk_q;
        if (nxt_idx == IW'(1)) begin
            next_byte = {seq_q, 4'(N - 1)};
        end else if (nxt_idx != IW'(L - 1)) begin
            next_byte = snap_q[pay_idx[PIW-1:0]];
        end
    end

    always_comb begin
        state_d    = state_q;
        dcnt_d     = dcnt_q;
        bit_cnt_d  = bit_cnt_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        chk_d      = chk_q;
        seq_d      = seq_q;
        started_d  = started_q;
        overrun_d  = overrun_q;
        snap_d     = snap_q;
        tx_d       = 1'b1;

        if (!en) begin
            dcnt_d = '0;
        end else if (edge_det) begin
            dcnt_d = (dcnt_q == DW'(DECIMATE - 1)) ? '0 : dcnt_q + DW'(1);
        end

        if (capture && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d    = S_START;
                    snap_d     = sample_bytes;
                    seq_d      = seq_q + 4'd1;
                    started_d  = 1'b1;
                    shift_d    = 8'hA5;
                    chk_d      = 8'h00;
                    byte_idx_d = '0;
                    bit_cnt_d  = '0;
                end
            end
            S_START: begin
                tx_d = 1'b0;
                if (bit_end) begin
                    bit_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = S_DATA;
                end else begin
                    bit_cnt_d = bit_cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                tx_d = shift_q[0];
                if (bit_end) begin
                    bit_cnt_d = '0;
                    shift_d   = shift_q >> 1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    bit_cnt_d = '0;
                    if (byte_idx_q == IW'(L - 1)) begin
                        state_d = S_IDLE;
                    end else begin
                        // Load the next byte straight away so there is no inter-byte gap.
                        state_d    = S_START;
                        byte_idx_d = nxt_idx;
                        shift_d    = next_byte;
                        chk_d      = (nxt_idx == IW'(L - 1)) ? chk_q : (chk_q ^ next_byte);
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            dcnt_q     <= '0;
            bit_cnt_q  <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            shift_q    <= '0;
            chk_q      <= '0;
            seq_q      <= 4'hF;
            started_q  <= 1'b0;
            overrun_q  <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            dcnt_q     <= dcnt_d;
            bit_cnt_q  <= bit_cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            chk_q      <= chk_d;
            seq_q      <= seq_d;
            started_q  <= started_d;
            overrun_q  <= overrun_d;
            tx_q       <= tx_d;
        end
    end

    // Edge-detect history and snapshot are pure data and need no reset.
    always_ff @(posedge clk) begin
        sc_q   <= sample_clk;
        snap_q <= snap_d;
    end

    assign tx_o      = tx_q;
    assign busy      = (state_q != S_IDLE);
    assign overrun   = overrun_q;
    assign frame_seq = started_q ? seq_q : 4'h0;

endmodule
